// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the fetch entry layout and the architectural widths.
package inst_fetch_queue_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstWidth     = 32;
    localparam logic [InstAddrWidth-1:0] ResetPc = 32'h1c00_0000;

    // One queued fetch result; adef marks a misaligned-address fault entry
    typedef struct packed {
        logic [InstAddrWidth-1:0] pc;
        logic [InstWidth-1:0]     inst;
        logic                     adef;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [InstAddrWidth-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_queue_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and a head read port.
// Flush and reset both empty the queue; push into a full queue is the caller's job to prevent.
module inst_queue_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic [PTR_W:0]   count,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && !rst && !flush;
        do_pop  = pop && !rst && !flush && (count != '0);
        head_c  = mem[rd_ptr];
        empty_c = (count == '0);
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-side requester: owns the PC, reads the combinational instruction ROM and
// queues {pc, inst, adef} for decode; back-end redirects flush the queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter logic [InstAddrWidth-1:0] RESET_PC = ResetPc,
    parameter int unsigned              DEPTH    = 4,
    parameter int unsigned              PTR_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_inst_en,
    output logic [InstAddrWidth-1:0] rom_inst_addr,
    input  logic [InstWidth-1:0]     rom_inst,
    input  logic                     redirect_valid,
    input  logic [InstAddrWidth-1:0] redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [InstAddrWidth-1:0] dec_pc,
    output logic [InstWidth-1:0]     dec_inst,
    output logic                     dec_adef
);

    localparam int unsigned EntryW = InstAddrWidth + InstWidth + 1;

    logic [InstAddrWidth-1:0] pc;
    logic                     halted;
    logic                     fetch_c;
    logic                     aligned_c;
    logic                     pop_c;
    fetch_entry_t             push_entry_c;
    fetch_entry_t             head_entry_c;
    logic [EntryW-1:0]        head_raw_c;
    logic [PTR_W:0]           fifo_count;
    logic                     fifo_empty_c;

    // Fetch gating uses only registered occupancy, so dec_ready never reaches the ROM
    always_comb begin
        aligned_c    = is_word_aligned(pc);
        fetch_c      = !rst && !redirect_valid && !halted
                       && (fifo_count < (PTR_W+1)'(DEPTH));
        rom_inst_en  = fetch_c && aligned_c;
        rom_inst_addr = pc;

        push_entry_c.pc   = pc;
        push_entry_c.inst = aligned_c ? rom_inst : '0;
        push_entry_c.adef = !aligned_c;

        dec_valid    = !rst && !fifo_empty_c;
        pop_c        = dec_valid && dec_ready && !redirect_valid;

        head_entry_c = fetch_entry_t'(head_raw_c);
        dec_pc       = dec_valid ? head_entry_c.pc   : '0;
        dec_inst     = dec_valid ? head_entry_c.inst : '0;
        dec_adef     = dec_valid ? head_entry_c.adef : 1'b0;
    end

    // PC and halt tracking: a misaligned fetch parks the PC until the next redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
        end else if (fetch_c) begin
            if (aligned_c) begin
                pc <= pc + InstAddrWidth'(4);
            end else begin
                halted <= 1'b1;
            end
        end
    end

    inst_queue_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fetch_c),
        .push_data (EntryW'(push_entry_c)),
        .pop       (pop_c),
        .head_c    (head_raw_c),
        .count     (fifo_count),
        .empty_c   (fifo_empty_c)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a combinational ROM model
// returning addr ^ 32'hA5A5_0000.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_inst_en;
    logic [31:0] rom_inst_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_adef;

    int vectors;
    int errors;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] ROM_XOR = 32'hA5A5_0000;

    inst_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rom_inst_en    (rom_inst_en),
        .rom_inst_addr  (rom_inst_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_inst       (dec_inst),
        .dec_adef       (dec_adef)
    );

    assign rom_inst = rom_inst_addr ^ ROM_XOR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, then releases it; caller is in the first post-reset cycle
    task automatic do_reset(input logic ready);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = ready;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b1;
        step();
        step();
        vectors++;
        if ({dec_valid, dec_adef, rom_inst_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b adef=%b en=%b want 0 0 0", dec_valid, dec_adef, rom_inst_en);
        end
        vectors++;
        if ({dec_pc, dec_inst} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got pc=%h inst=%h want 0 0", dec_pc, dec_inst);
        end
        vectors++;
        if (rom_inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr got %h want %h", rom_inst_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset(1'b1);
        vectors++;
        if (rom_inst_en !== 1'b1 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch got en=%b v=%b want 1 0", rom_inst_en, dec_valid);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            exp = RST_PC + 32'(4 * i);
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp || dec_inst !== (exp ^ ROM_XOR) || dec_adef !== 1'b0) begin
                errors++;
                $display("FAIL stream[%0d] got v=%b pc=%h inst=%h adef=%b want 1 %h %h 0",
                         i, dec_valid, dec_pc, dec_inst, dec_adef, exp, exp ^ ROM_XOR);
            end
            step();
        end
    endtask

    task automatic test_full();
        logic [31:0] exp;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (rom_inst_en !== 1'b0 || rom_inst_addr !== 32'h1c00_0010) begin
            errors++;
            $display("FAIL full_hold got en=%b addr=%h want 0 1c000010", rom_inst_en, rom_inst_addr);
        end
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== RST_PC) begin
            errors++;
            $display("FAIL full_head got v=%b pc=%h want 1 %h", dec_valid, dec_pc, RST_PC);
        end
        dec_ready = 1'b1;
        #1;
        vectors++;
        if (rom_inst_en !== 1'b0) begin
            errors++;
            $display("FAIL full_gate got en=%b want 0", rom_inst_en);
        end
        for (int i = 0; i < 4; i++) begin
            exp = RST_PC + 32'(4 * i);
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp || dec_inst !== (exp ^ ROM_XOR)) begin
                errors++;
                $display("FAIL drain[%0d] got v=%b pc=%h inst=%h want 1 %h %h",
                         i, dec_valid, dec_pc, dec_inst, exp, exp ^ ROM_XOR);
            end
            step();
            if (i == 0) begin
                vectors++;
                if (rom_inst_en !== 1'b1 || rom_inst_addr !== 32'h1c00_0010) begin
                    errors++;
                    $display("FAIL fetch_resume got en=%b addr=%h want 1 1c000010", rom_inst_en, rom_inst_addr);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0100;
        dec_ready = 1'b1;
        #1;
        vectors++;
        if (rom_inst_en !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_fetch got en=%b want 0", rom_inst_en);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || rom_inst_en !== 1'b1 || rom_inst_addr !== 32'h1c00_0100) begin
            errors++;
            $display("FAIL redir_flush got v=%b en=%b addr=%h want 0 1 1c000100", dec_valid, rom_inst_en, rom_inst_addr);
        end
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h1c00_0100) begin
            errors++;
            $display("FAIL redir_target got v=%b pc=%h want 1 1c000100", dec_valid, dec_pc);
        end
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h1c00_0104) begin
            errors++;
            $display("FAIL redir_next got v=%b pc=%h want 1 1c000104", dec_valid, dec_pc);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0102;
        dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || rom_inst_en !== 1'b0 || rom_inst_addr !== 32'h1c00_0102) begin
            errors++;
            $display("FAIL adef_issue got v=%b en=%b addr=%h want 0 0 1c000102", dec_valid, rom_inst_en, rom_inst_addr);
        end
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_adef !== 1'b1 || dec_inst !== 32'h0 || dec_pc !== 32'h1c00_0102) begin
            errors++;
            $display("FAIL adef_entry got v=%b adef=%b inst=%h pc=%h want 1 1 0 1c000102",
                     dec_valid, dec_adef, dec_inst, dec_pc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dec_valid !== 1'b0 || rom_inst_en !== 1'b0) begin
                errors++;
                $display("FAIL adef_halt[%0d] got v=%b en=%b want 0 0", i, dec_valid, rom_inst_en);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0200;
        step();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (rom_inst_en !== 1'b1 || rom_inst_addr !== 32'h1c00_0200) begin
            errors++;
            $display("FAIL adef_resume got en=%b addr=%h want 1 1c000200", rom_inst_en, rom_inst_addr);
        end
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h1c00_0200 || dec_adef !== 1'b0
            || dec_inst !== (32'h1c00_0200 ^ ROM_XOR)) begin
            errors++;
            $display("FAIL adef_after got v=%b pc=%h adef=%b inst=%h want 1 1c000200 0 %h",
                     dec_valid, dec_pc, dec_adef, dec_inst, 32'h1c00_0200 ^ ROM_XOR);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            dec_ready = (i >= 4) ? i[0] : 1'b0;
            step();
        end
        rst = 1'b1;
        dec_ready = 1'b1;
        step();
        vectors++;
        if ({dec_valid, dec_adef, rom_inst_en} !== 3'b000 || {dec_pc, dec_inst} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b adef=%b en=%b pc=%h inst=%h want all 0",
                     dec_valid, dec_adef, rom_inst_en, dec_pc, dec_inst);
        end
        rst = 1'b0;
        #1;
        step();
        vectors++;
        if (dec_valid !== 1'b1 || dec_pc !== RST_PC) begin
            errors++;
            $display("FAIL mid_restart got v=%b pc=%h want 1 %h", dec_valid, dec_pc, RST_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFF8;
        exp[1] = 32'hFFFF_FFFC;
        exp[2] = 32'h0000_0000;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        #1;
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dec_valid !== 1'b1 || dec_pc !== exp[i] || dec_inst !== (exp[i] ^ ROM_XOR) || dec_adef !== 1'b0) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%b pc=%h inst=%h adef=%b want 1 %h %h 0",
                         i, dec_valid, dec_pc, dec_inst, dec_adef, exp[i], exp[i] ^ ROM_XOR);
            end
            step();
        end
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
